ahb_sram_slave: RTL and testbench
=================================

Name: ahb_sram_slave

Overview:
AHB-Lite responder backed by an internal word-organised memory array. It produces the HRDATA/HREADYOUT/HRESP response that the matrix slave-to-master multiplexer returns to the master, and consumes the broadcast HREADY. The block has a configurable number of wait states, byte/halfword/word write strobes, and a two-cycle ERROR response for illegal accesses. It is the standard memory slave for matrix integration and testing.

Parameters:
MEM_AW, 10, word-address bits of the array (depth 2^MEM_AW words of 32 bits, default 4 KB)
REGION_AW, 16, byte-address bits decoded inside the HSEL region; the bits above are ignored
WAIT_STATES, 1, HREADYOUT-low cycles inserted in every OKAY data phase (0..15)

Ports:
HCLK  input  1  system clock
HRESETn  input  1  asynchronous active-low reset
HSEL  input  1  slave select from the address decoder
HADDR  input  32  byte address (address phase)
HTRANS  input  2  transfer type: IDLE=00, BUSY=01, NONSEQ=10, SEQ=11
HWRITE  input  1  1=write, 0=read
HSIZE  input  3  0=byte, 1=halfword, 2=word
HBURST  input  3  accepted and ignored
HWDATA  input  32  write data (data phase)
HREADY  input  1  bus ready from the response mux
HRDATA  output  32  read data
HREADYOUT  output  1  slave ready
HRESP  output  1  0=OKAY, 1=ERROR

Behaviour:
- Clock HCLK; reset HRESETn is asynchronous and active-low. Reset values: state=IDLE, HREADYOUT=1, HRESP=0, HRDATA=0, wait counter=0, all latched address-phase registers=0. Memory contents are not reset.
- Accept condition, sampled at the HCLK edge: HSEL & HREADY & HTRANS[1]. On accept, latch the word index HADDR[MEM_AW+1:2], HWRITE, HSIZE, the byte-lane mask and the error flag.
- HSEL & HREADY with HTRANS IDLE or BUSY: no data phase; the slave stays IDLE and answers zero-wait OKAY.
- HREADY low: never accept; latched registers hold their values.
- Error flag is set if any of these holds: HSIZE>2; halfword with HADDR[0]=1; word with HADDR[1:0]!=0; HADDR[REGION_AW-1:MEM_AW+2]!=0.
- Byte lanes: byte → lane HADDR[1:0]; halfword → lanes {HADDR[1],0} and {HADDR[1],1}; word → all four lanes.
- States:
  - IDLE: HREADYOUT=1, HRESP=0. Accept with error → ERR1. Accept without error → DATA, counter loaded with WAIT_STATES.
  - DATA: HREADYOUT=(cnt==0), HRESP=0. While cnt>0, decrement cnt. At cnt==0 the data phase completes at the edge. A new accept at that same edge pipelines directly into DATA or ERR1; otherwise go to IDLE.
  - ERR1: HREADYOUT=0, HRESP=1, always for exactly one cycle; next state ERR2. No wait states are applied.
  - ERR2: HREADYOUT=1, HRESP=1. Accepts a new transfer at this edge exactly as IDLE does; the master may also drive IDLE here.
- Writes: commit at the completing edge of DATA, using the latched byte lanes and the current HWDATA; only the enabled bytes change. Errored or aborted transfers never write.
- Reads: HRDATA = mem[latched index] throughout a read DATA phase; HRDATA=0 in all other states. The value is valid when HREADYOUT=1.
- Back-to-back write then read of the same word: the read returns the newly written data, because the commit precedes the read data phase.
- Reset asserted mid-phase: immediate return to IDLE, HREADYOUT=1; a pending write is discarded.
- With WAIT_STATES=0, every OKAY transfer completes in a single data-phase cycle.

Test Plan:
- WAIT_STATES=1: word write 0xDEADBEEF to 0x100, then word read of 0x100 → write phase shows HREADYOUT=0 for 1 cycle then 1; read phase shows HRDATA=0xDEADBEEF with HRESP=0.
- Byte writes 0x11@0x200, 0x22@0x201, halfword 0x4433@0x202, then word read of 0x200 → 0x44332211.
- Pipelined NONSEQ write 0xA5A5A5A5@0x300 immediately followed by read @0x300, HREADY honoured → read returns 0xA5A5A5A5 with no extra stall beyond WAIT_STATES.
- Word read @0x102 and an access @0x8000 (with MEM_AW=10) → each gives HREADYOUT=0/HRESP=1 for one cycle, then HREADYOUT=1/HRESP=1; a word write @0x102 leaves memory unchanged.
- HTRANS=BUSY or IDLE with HSEL=1, and NONSEQ with HREADY=0 → no data phase, HREADYOUT stays 1, no memory change.
- Word write 0x12345678@0x40 over existing 0x0, with HRESETn pulsed low during the wait cycle → HREADYOUT=1 immediately; a later read of 0x40 returns 0x00000000.

Source files
------------

// File: rtl/ahb_sram_slave.sv
// AHB-Lite memory slave: word-organised SRAM with programmable wait states,
// byte/halfword/word write strobes and a two-cycle ERROR response.
module ahb_sram_slave #(
    parameter int unsigned MEM_AW      = 10,
    parameter int unsigned REGION_AW   = 16,
    parameter int unsigned WAIT_STATES = 1
) (
    input  logic        HCLK,
    input  logic        HRESETn,
    input  logic        HSEL,
    input  logic [31:0] HADDR,
    input  logic [1:0]  HTRANS,
    input  logic        HWRITE,
    input  logic [2:0]  HSIZE,
    input  logic [2:0]  HBURST,
    input  logic [31:0] HWDATA,
    input  logic        HREADY,
    output logic [31:0] HRDATA,
    output logic        HREADYOUT,
    output logic        HRESP
);

    localparam logic [3:0]  WaitInit   = 4'(WAIT_STATES);
    localparam logic [63:0] RegionHi   = (64'd1 << REGION_AW) - 64'd1;
    localparam logic [63:0] RegionLo   = (64'd1 << (MEM_AW + 2)) - 64'd1;
    // Address bits inside the region but above the array must be zero.
    localparam logic [31:0] RegionMask = 32'(RegionHi & ~RegionLo);

    typedef enum logic [1:0] {StIdle, StData, StErr1, StErr2} state_e;

    state_e              state_q, state_d;
    logic [3:0]          cnt_q, cnt_d;
    logic [MEM_AW-1:0]   idx_q, idx_d;
    logic                write_q, write_d;
    logic [2:0]          size_q, size_d;
    logic [3:0]          lanes_q, lanes_d;
    logic                err_q, err_d;

    logic [31:0]         mem [2**MEM_AW];

    logic                accept;
    logic                take_new;
    logic                addr_err;
    logic [3:0]          addr_lanes;
    logic                mem_we;

    assign accept = HSEL & HREADY & HTRANS[1];

    always_comb begin
        addr_err = (HSIZE > 3'd2)
                 | ((HSIZE == 3'd1) & HADDR[0])
                 | ((HSIZE == 3'd2) & (|HADDR[1:0]))
                 | (|(HADDR & RegionMask));
    end

    always_comb begin
        addr_lanes = 4'b0000;
        case (HSIZE)
            3'd0:    addr_lanes = 4'b0001 << HADDR[1:0];
            3'd1:    addr_lanes = HADDR[1] ? 4'b1100 : 4'b0011;
            3'd2:    addr_lanes = 4'b1111;
            default: addr_lanes = 4'b0000;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        idx_d     = idx_q;
        write_d   = write_q;
        size_d    = size_q;
        lanes_d   = lanes_q;
        err_d     = err_q;
        HREADYOUT = 1'b1;
        HRESP     = 1'b0;
        take_new  = 1'b0;

        unique case (state_q)
            StIdle: take_new = accept;
            StData: begin
                HREADYOUT = (cnt_q == 4'd0);
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    state_d  = StIdle;
                    take_new = accept;
                end
            end
            StErr1: begin
                HREADYOUT = 1'b0;
                HRESP     = 1'b1;
                state_d   = StErr2;
            end
            StErr2: begin
                HRESP    = 1'b1;
                state_d  = StIdle;
                take_new = accept;
            end
            default: state_d = StIdle;
        endcase

        if (take_new) begin
            idx_d   = HADDR[MEM_AW+1:2];
            write_d = HWRITE;
            size_d  = HSIZE;
            lanes_d = addr_lanes;
            err_d   = addr_err;
            state_d = addr_err ? StErr1 : StData;
            cnt_d   = addr_err ? 4'd0 : WaitInit;
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q <= StIdle;
            cnt_q   <= 4'd0;
            idx_q   <= '0;
            write_q <= 1'b0;
            size_q  <= 3'd0;
            lanes_q <= 4'b0000;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            write_q <= write_d;
            size_q  <= size_d;
            lanes_q <= lanes_d;
            err_q   <= err_d;
        end
    end

    // Commit on the completing edge of a write data phase.
    assign mem_we = HRESETn & (state_q == StData) & (cnt_q == 4'd0) & write_q;

    always_ff @(posedge HCLK) begin
        if (mem_we) begin
            for (int i = 0; i < 4; i++) begin
                if (lanes_q[i]) begin
                    mem[idx_q][8*i +: 8] <= HWDATA[8*i +: 8];
                end
            end
        end
    end

    always_comb begin
        HRDATA = 32'h0;
        if (state_q == StData && !write_q) begin
            HRDATA = mem[idx_q];
        end
    end

    logic unused_sigs;
    assign unused_sigs = ^{HBURST, size_q, err_q};

endmodule

// File: tb/tb_ahb_sram_slave.sv
// Directed bench for ahb_sram_slave (default parameters, WAIT_STATES=1).
module tb_ahb_sram_slave;

    logic        HCLK = 1'b0;
    logic        HRESETn;
    logic        HSEL;
    logic [31:0] HADDR;
    logic [1:0]  HTRANS;
    logic        HWRITE;
    logic [2:0]  HSIZE;
    logic [2:0]  HBURST;
    logic [31:0] HWDATA;
    logic        HREADY;
    logic [31:0] HRDATA;
    logic        HREADYOUT;
    logic        HRESP;
    logic        hready_low;

    int total = 0;
    int bad   = 0;

    assign HREADY = hready_low ? 1'b0 : HREADYOUT;

    ahb_sram_slave dut (
        .HCLK      (HCLK),
        .HRESETn   (HRESETn),
        .HSEL      (HSEL),
        .HADDR     (HADDR),
        .HTRANS    (HTRANS),
        .HWRITE    (HWRITE),
        .HSIZE     (HSIZE),
        .HBURST    (HBURST),
        .HWDATA    (HWDATA),
        .HREADY    (HREADY),
        .HRDATA    (HRDATA),
        .HREADYOUT (HREADYOUT),
        .HRESP     (HRESP)
    );

    always #5 HCLK = ~HCLK;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // Single non-pipelined transfer; called and returns 1 time unit after a rising edge.
    task automatic xfer(input logic wr, input logic [2:0] size, input logic [31:0] addr,
                        input logic [31:0] wdata, output logic [31:0] rdata,
                        output logic resp0, output logic respf, output int waits);
        HSEL   = 1'b1;
        HTRANS = 2'b10;
        HADDR  = addr;
        HWRITE = wr;
        HSIZE  = size;
        @(posedge HCLK); #1;
        HTRANS = 2'b00;
        HWDATA = wdata;
        waits  = 0;
        resp0  = HRESP;
        while (!HREADYOUT && waits < 20) begin
            waits++;
            @(posedge HCLK); #1;
        end
        respf = HRESP;
        rdata = HRDATA;
        @(posedge HCLK); #1;
    endtask

    typedef struct {
        logic        wr;
        logic [2:0]  size;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    vec_t vecs[15];

    initial begin
        logic [31:0] rd;
        logic        r0, rf;
        int          w;

        vecs[0]  = '{1'b1, 3'd2, 32'h0000_0100, 32'hDEAD_BEEF, 32'h0, 1'b0};
        vecs[1]  = '{1'b0, 3'd2, 32'h0000_0100, 32'h0,         32'hDEAD_BEEF, 1'b0};
        vecs[2]  = '{1'b1, 3'd0, 32'h0000_0200, 32'h0000_0011, 32'h0, 1'b0};
        vecs[3]  = '{1'b1, 3'd0, 32'h0000_0201, 32'h0000_2200, 32'h0, 1'b0};
        vecs[4]  = '{1'b1, 3'd1, 32'h0000_0202, 32'h4433_0000, 32'h0, 1'b0};
        vecs[5]  = '{1'b0, 3'd2, 32'h0000_0200, 32'h0,         32'h4433_2211, 1'b0};
        vecs[6]  = '{1'b0, 3'd2, 32'h0000_0102, 32'h0,         32'h0, 1'b1};
        vecs[7]  = '{1'b0, 3'd2, 32'h0000_8000, 32'h0,         32'h0, 1'b1};
        vecs[8]  = '{1'b1, 3'd2, 32'h0000_0102, 32'hFFFF_FFFF, 32'h0, 1'b1};
        vecs[9]  = '{1'b1, 3'd1, 32'h0000_0101, 32'hFFFF_FFFF, 32'h0, 1'b1};
        vecs[10] = '{1'b1, 3'd3, 32'h0000_0100, 32'hFFFF_FFFF, 32'h0, 1'b1};
        vecs[11] = '{1'b0, 3'd2, 32'h0000_0100, 32'h0,         32'hDEAD_BEEF, 1'b0};
        vecs[12] = '{1'b1, 3'd0, 32'h0000_0103, 32'h7700_0000, 32'h0, 1'b0};
        vecs[13] = '{1'b0, 3'd1, 32'h0000_0102, 32'h0,         32'h77AD_BEEF, 1'b0};
        vecs[14] = '{1'b0, 3'd2, 32'h0001_0100, 32'h0,         32'h77AD_BEEF, 1'b0};

        HRESETn    = 1'b0;
        HSEL       = 1'b0;
        HADDR      = 32'h0;
        HTRANS     = 2'b00;
        HWRITE     = 1'b0;
        HSIZE      = 3'd0;
        HBURST     = 3'd0;
        HWDATA     = 32'h0;
        hready_low = 1'b0;

        repeat (2) @(posedge HCLK);
        #1;
        chk("reset_hreadyout", {31'h0, HREADYOUT}, 32'h1);
        chk("reset_hresp", {31'h0, HRESP}, 32'h0);
        chk("reset_hrdata", HRDATA, 32'h0);
        HRESETn = 1'b1;
        @(posedge HCLK); #1;

        for (int i = 0; i < 15; i++) begin
            xfer(vecs[i].wr, vecs[i].size, vecs[i].addr, vecs[i].wdata, rd, r0, rf, w);
            chk($sformatf("vec%0d_waits", i), 32'(w), 32'd1);
            chk($sformatf("vec%0d_resp_first", i), {31'h0, r0}, {31'h0, vecs[i].exp_err});
            chk($sformatf("vec%0d_resp_final", i), {31'h0, rf}, {31'h0, vecs[i].exp_err});
            chk($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rdata);
        end

        // Pipelined write then read of the same word.
        HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b1; HSIZE = 3'd2; HADDR = 32'h300;
        @(posedge HCLK); #1;
        chk("pipe_wr_wait", {31'h0, HREADYOUT}, 32'h0);
        HWDATA = 32'hA5A5_A5A5; HWRITE = 1'b0;
        @(posedge HCLK); #1;
        chk("pipe_wr_done", {31'h0, HREADYOUT}, 32'h1);
        @(posedge HCLK); #1;
        chk("pipe_rd_wait", {31'h0, HREADYOUT}, 32'h0);
        HTRANS = 2'b00;
        @(posedge HCLK); #1;
        chk("pipe_rd_ready", {31'h0, HREADYOUT}, 32'h1);
        chk("pipe_rd_data", HRDATA, 32'hA5A5_A5A5);
        chk("pipe_rd_resp", {31'h0, HRESP}, 32'h0);
        @(posedge HCLK); #1;

        // BUSY, IDLE and a stalled NONSEQ must not start a data phase.
        HSEL = 1'b1; HWRITE = 1'b1; HSIZE = 3'd2; HADDR = 32'h100; HWDATA = 32'h0BAD_0BAD;
        HTRANS = 2'b01;
        @(posedge HCLK); #1;
        chk("busy_ready", {31'h0, HREADYOUT}, 32'h1);
        HTRANS = 2'b00;
        @(posedge HCLK); #1;
        chk("idle_ready", {31'h0, HREADYOUT}, 32'h1);
        hready_low = 1'b1; HTRANS = 2'b10;
        repeat (2) @(posedge HCLK);
        #1;
        chk("stall_ready", {31'h0, HREADYOUT}, 32'h1);
        chk("stall_resp", {31'h0, HRESP}, 32'h0);
        HTRANS = 2'b00; hready_low = 1'b0;
        @(posedge HCLK); #1;
        xfer(1'b0, 3'd2, 32'h100, 32'h0, rd, r0, rf, w);
        chk("no_phase_mem", rd, 32'h77AD_BEEF);

        // Reset during the wait cycle discards the pending write.
        xfer(1'b1, 3'd2, 32'h40, 32'h0, rd, r0, rf, w);
        HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b1; HSIZE = 3'd2; HADDR = 32'h40;
        @(posedge HCLK); #1;
        chk("rst_pre_wait", {31'h0, HREADYOUT}, 32'h0);
        HTRANS = 2'b00; HWDATA = 32'h1234_5678;
        HRESETn = 1'b0;
        #1;
        chk("rst_async_ready", {31'h0, HREADYOUT}, 32'h1);
        @(posedge HCLK); #1;
        HRESETn = 1'b1;
        @(posedge HCLK); #1;
        xfer(1'b0, 3'd2, 32'h40, 32'h0, rd, r0, rf, w);
        chk("rst_discard_data", rd, 32'h0);
        chk("rst_discard_waits", 32'(w), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
